// File: rtl/apb_master_bridge_pkg.sv
// Shared types and defaults for the APB requester bridge.
// State encoding is fixed so it reads the same in waveforms and in software debug dumps.
package apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    typedef struct packed {
        logic err;
        logic timeout;
    } rsp_status_t;

    localparam int unsigned APB_TIMEOUT_CYCLES_DEFAULT = 16;

    // Counter width needed to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response port plus APB requester signals of the bridge.
// master = the bridge itself, slave = initiator and peripheral side.
interface apb_master_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge_wdt_counter.sv
// Wait-state watchdog: counts enabled cycles since clear, flags the LIMIT-th one.
// Latency: tc is combinational in the cycle that would complete LIMIT enabled cycles.
// Backpressure: none; holds at terminal count until cleared.
module apb_wdt_counter
    import apb_master_pkg::*;
#(
    parameter int unsigned LIMIT = APB_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int unsigned CW = cnt_width(LIMIT);

    logic [CW-1:0] count;

    assign tc = en && (count == CW'(LIMIT - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: one valid/ready command in, one APB transfer out, response held until taken.
// Latency: accept->SETUP->ACCESS->RESP, 4 cycles min per transfer, +1 per PREADY-low cycle.
// Backpressure: req_ready only in IDLE; RESP held until rsp_ready. Watchdog: APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    apb_master_bridge_if.master   bus
);
    apb_state_t            state;
    apb_state_t            state_nxt;
    logic                  accept;
    logic                  done;
    logic                  timeout_hit;

    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    rsp_status_t           status_q;

    assign accept = bus.req_valid && (state == ST_IDLE);
    assign done   = (state == ST_ACCESS) && bus.PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
    logic wdt_clr;
    logic wdt_en;

    assign wdt_clr = (state == ST_SETUP);
    assign wdt_en  = (state == ST_ACCESS) && !bus.PREADY;

    apb_wdt_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdt (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clr     (wdt_clr),
        .en      (wdt_en),
        .tc      (timeout_hit)
    );
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: if (done || timeout_hit) state_nxt = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State resets asynchronously, so PSEL/PENABLE decoded from it drop at once.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else if (accept) begin
            paddr_q  <= bus.req_addr;
            pwdata_q <= bus.req_wdata;
            pwrite_q <= bus.req_write;
        end
    end

    // PRDATA/PSLVERR are only meaningful in the completing ACCESS cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rdata_q  <= '0;
            status_q <= '0;
        end else if (done) begin
            rdata_q  <= pwrite_q ? '0 : bus.PRDATA;
            status_q <= '{err: bus.PSLVERR, timeout: 1'b0};
        end else if (timeout_hit) begin
            rdata_q  <= '0;
            status_q <= '{err: 1'b1, timeout: 1'b1};
        end
    end

    assign bus.req_ready   = (state == ST_IDLE);
    assign bus.rsp_valid   = (state == ST_RESP);
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = status_q.err;
    assign bus.rsp_timeout = status_q.timeout;

    assign bus.PSEL        = (state == ST_SETUP) || (state == ST_ACCESS);
    assign bus.PENABLE     = (state == ST_ACCESS);
    assign bus.PADDR       = paddr_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PWDATA      = pwdata_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: write, wait-state read, slave error, response stall,
// watchdog (or unbounded wait without APB_MASTER_TIMEOUT_EN) and reset during ACCESS.
module tb_apb_master_bridge;
    logic PCLK = 1'b0;
    logic PRESETn;
    int   total = 0;
    int   bad   = 0;

    always #5 PCLK = ~PCLK;

    apb_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_master_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        PRESETn       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        repeat (3) step();

        // reset values
        chk("rst_psel",      bus.PSEL, 0);
        chk("rst_penable",   bus.PENABLE, 0);
        chk("rst_pwrite",    bus.PWRITE, 0);
        chk("rst_paddr",     bus.PADDR, 0);
        chk("rst_pwdata",    bus.PWDATA, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rdata",     bus.rsp_rdata, 0);
        chk("rst_err",       bus.rsp_err, 0);
        chk("rst_timeout",   bus.rsp_timeout, 0);
        chk("rst_req_ready", bus.req_ready, 1);
        PRESETn = 1'b1;
        step();

        // write 0xC <- 0xA5, zero wait states
        bus.req_valid = 1'b1; bus.req_write = 1'b1;
        bus.req_addr  = 32'h0000_000C; bus.req_wdata = 32'h0000_00A5;
        bus.PREADY = 1'b1; bus.PRDATA = 32'h0000_0099;
        step();
        chk("w_setup_psel",    bus.PSEL, 1);
        chk("w_setup_penable", bus.PENABLE, 0);
        chk("w_setup_paddr",   bus.PADDR, 32'h0000_000C);
        chk("w_setup_pwdata",  bus.PWDATA, 32'h0000_00A5);
        chk("w_setup_pwrite",  bus.PWRITE, 1);
        chk("w_setup_req_rdy", bus.req_ready, 0);
        bus.req_valid = 1'b0; bus.req_addr = 32'hFFFF_FFFF; bus.req_wdata = 32'hFFFF_FFFF;
        step();
        chk("w_acc_psel",      bus.PSEL, 1);
        chk("w_acc_penable",   bus.PENABLE, 1);
        chk("w_acc_paddr",     bus.PADDR, 32'h0000_000C);
        chk("w_acc_rsp_valid", bus.rsp_valid, 0);
        step();
        chk("w_rsp_valid",     bus.rsp_valid, 1);
        chk("w_rsp_rdata",     bus.rsp_rdata, 0);
        chk("w_rsp_err",       bus.rsp_err, 0);
        chk("w_rsp_psel",      bus.PSEL, 0);
        chk("w_rsp_penable",   bus.PENABLE, 0);
        bus.rsp_ready = 1'b1;
        step();
        chk("w_idle_rsp_valid", bus.rsp_valid, 0);
        chk("w_idle_req_ready", bus.req_ready, 1);
        chk("w_idle_paddr_hold", bus.PADDR, 32'h0000_000C);
        bus.rsp_ready = 1'b0;

        // read 0x8, three wait states, junk PRDATA/PSLVERR while waiting
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_0008;
        bus.PREADY = 1'b0; bus.PRDATA = 32'h0000_DEAD; bus.PSLVERR = 1'b1;
        step();
        bus.req_valid = 1'b0; bus.req_addr = 32'h0000_00FF;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("r_wait_penable", bus.PENABLE, 1);
            chk("r_wait_paddr",   bus.PADDR, 32'h0000_0008);
            chk("r_wait_rsp_vld", bus.rsp_valid, 0);
            step();
        end
        chk("r_last_acc_psel", bus.PSEL, 1);
        bus.PREADY = 1'b1; bus.PRDATA = 32'h0000_0012; bus.PSLVERR = 1'b0;
        step();
        chk("r_rsp_valid", bus.rsp_valid, 1);
        chk("r_rsp_rdata", bus.rsp_rdata, 32'h0000_0012);
        chk("r_rsp_err",   bus.rsp_err, 0);
        chk("r_paddr",     bus.PADDR, 32'h0000_0008);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;

        // read 0x20 completing with PSLVERR
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_0020;
        bus.PREADY = 1'b1; bus.PSLVERR = 1'b1; bus.PRDATA = 32'h0000_0077;
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        chk("e_rsp_valid",   bus.rsp_valid, 1);
        chk("e_rsp_err",     bus.rsp_err, 1);
        chk("e_rsp_timeout", bus.rsp_timeout, 0);
        chk("e_rsp_rdata",   bus.rsp_rdata, 32'h0000_0077);

        // response stalled 5 cycles while a new request waits
        bus.PSLVERR = 1'b0; bus.PRDATA = '0;
        bus.req_valid = 1'b1; bus.req_write = 1'b1;
        bus.req_addr = 32'h0000_0030; bus.req_wdata = 32'h0000_0055;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("s_rsp_valid", bus.rsp_valid, 1);
            chk("s_rsp_rdata", bus.rsp_rdata, 32'h0000_0077);
            chk("s_rsp_err",   bus.rsp_err, 1);
            chk("s_req_ready", bus.req_ready, 0);
            chk("s_paddr",     bus.PADDR, 32'h0000_0020);
        end
        bus.rsp_ready = 1'b1;
        step();
        chk("s_idle_rsp_valid", bus.rsp_valid, 0);
        chk("s_idle_req_ready", bus.req_ready, 1);
        chk("s_idle_psel",      bus.PSEL, 0);
        bus.rsp_ready = 1'b0;
        step();
        chk("s2_setup_psel",   bus.PSEL, 1);
        chk("s2_setup_paddr",  bus.PADDR, 32'h0000_0030);
        chk("s2_setup_pwrite", bus.PWRITE, 1);
        chk("s2_setup_pwdata", bus.PWDATA, 32'h0000_0055);
        bus.req_valid = 1'b0; bus.PRDATA = 32'h0000_0099;
        step();
        step();
        chk("s2_rsp_valid", bus.rsp_valid, 1);
        chk("s2_rsp_rdata", bus.rsp_rdata, 0);
        chk("s2_rsp_err",   bus.rsp_err, 0);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;

        // PREADY stuck low
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_0040;
        bus.PREADY = 1'b0; bus.PRDATA = 32'h0000_BEEF;
        step();
        bus.req_valid = 1'b0;
        step();
`ifdef APB_MASTER_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            step();
            chk("t_wait_psel",    bus.PSEL, 1);
            chk("t_wait_rsp_vld", bus.rsp_valid, 0);
        end
        step();
        chk("t_rsp_valid",   bus.rsp_valid, 1);
        chk("t_rsp_err",     bus.rsp_err, 1);
        chk("t_rsp_timeout", bus.rsp_timeout, 1);
        chk("t_rsp_rdata",   bus.rsp_rdata, 0);
        chk("t_psel",        bus.PSEL, 0);
`else
        for (int i = 0; i < 20; i++) begin
            step();
            chk("n_wait_penable", bus.PENABLE, 1);
            chk("n_wait_rsp_vld", bus.rsp_valid, 0);
        end
        bus.PREADY = 1'b1;
        step();
        chk("n_rsp_valid",   bus.rsp_valid, 1);
        chk("n_rsp_rdata",   bus.rsp_rdata, 32'h0000_BEEF);
        chk("n_rsp_timeout", bus.rsp_timeout, 0);
        chk("n_rsp_err",     bus.rsp_err, 0);
`endif
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;

        // reset asserted mid-ACCESS
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h0000_0050;
        bus.PREADY = 1'b0;
        step();
        bus.req_valid = 1'b0;
        step();
        chk("x_acc_penable", bus.PENABLE, 1);
        #2 PRESETn = 1'b0;
        #1;
        chk("x_rst_psel",      bus.PSEL, 0);
        chk("x_rst_penable",   bus.PENABLE, 0);
        chk("x_rst_rsp_valid", bus.rsp_valid, 0);
        chk("x_rst_paddr",     bus.PADDR, 0);
        step();
        PRESETn = 1'b1;
        step();
        chk("x_rel_req_ready", bus.req_ready, 1);
        chk("x_rel_psel",      bus.PSEL, 0);
        chk("x_rel_rsp_valid", bus.rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
